// File: rtl/rf_access_sequencer.sv
// rf_access_sequencer: grants one register-file access per cycle. The grant
// goes to one of two writeback sources or to a single operand-fetch reader.
// A1 is shared between the write address and read address 1. A bounded
// write-streak counter keeps a pending read from waiting forever.
module rf_access_sequencer #(
  parameter int N             = 32,
  parameter int MAX_WR_STREAK = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr0_valid,
  input  logic [4:0]   wr0_addr,
  input  logic [N-1:0] wr0_data,
  output logic         wr0_ready,
  input  logic         wr1_valid,
  input  logic [4:0]   wr1_addr,
  input  logic [N-1:0] wr1_data,
  output logic         wr1_ready,
  input  logic         rd_valid,
  input  logic [4:0]   rd_a1,
  input  logic [4:0]   rd_a2,
  output logic         rd_ready,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_rd1,
  output logic [N-1:0] rsp_rd2,
  output logic         rf_we,
  output logic [4:0]   rf_a1,
  output logic [4:0]   rf_a2,
  output logic [N-1:0] rf_wd,
  input  logic [N-1:0] rf_rd1,
  input  logic [N-1:0] rf_rd2
);

  localparam int SW = $clog2(MAX_WR_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_STREAK);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_WR0,
    GNT_WR1,
    GNT_RD
  } grant_e;

  grant_e        grant;
  logic          rr_ptr;   // 0: wr0 wins the next tie, 1: wr1 wins
  logic [SW-1:0] streak;   // write grants in a row while a read waited

  // Choose this cycle's single grant: forced read, then writes, then read.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant = GNT_IDLE;
    if (reset) begin
      grant = GNT_IDLE;
    end else if (rd_valid && (streak == STREAK_MAX)) begin
      grant = GNT_RD;
    end else if (wr0_valid && wr1_valid) begin
      grant = rr_ptr ? GNT_WR1 : GNT_WR0;
    end else if (wr0_valid) begin
      grant = GNT_WR0;
    end else if (wr1_valid) begin
      grant = GNT_WR1;
    end else if (rd_valid) begin
      grant = GNT_RD;
    end
  end

  // Decode the grant into handshakes and the register-file port drive.
  always_comb begin
    wr0_ready = (grant == GNT_WR0);
    wr1_ready = (grant == GNT_WR1);
    rd_ready  = (grant == GNT_RD);
    rf_we     = 1'b0;
    rf_a1     = rd_a1;
    rf_a2     = rd_a2;
    rf_wd     = '0;
    case (grant)
      GNT_WR0: begin
        rf_we = 1'b1;
        rf_a1 = wr0_addr;
        rf_wd = wr0_data;
      end
      GNT_WR1: begin
        rf_we = 1'b1;
        rf_a1 = wr1_addr;
        rf_wd = wr1_data;
      end
      default: ;
    endcase
  end

  // Round-robin pointer, write-streak counter and registered read response.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      rr_ptr    <= 1'b0;
      streak    <= '0;
      rsp_valid <= 1'b0;
      rsp_rd1   <= '0;
      rsp_rd2   <= '0;
    end else begin
      rsp_valid <= (grant == GNT_RD);
      if (grant == GNT_RD) begin
        rsp_rd1 <= rf_rd1;
        rsp_rd2 <= rf_rd2;
      end

      if (grant == GNT_WR0) begin
        rr_ptr <= 1'b1;
      end else if (grant == GNT_WR1) begin
        rr_ptr <= 1'b0;
      end

      if (!rd_valid || (grant == GNT_RD)) begin
        streak <= '0;
      end else if ((grant == GNT_WR0 || grant == GNT_WR1) && (streak != STREAK_MAX)) begin
        streak <= streak + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Testbench for rf_access_sequencer: directed scenarios plus randomized
// traffic. All outputs are compared against a grant/memory reference model.
module tb_rf_access_sequencer;

  localparam int MAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr0_valid, wr1_valid, rd_valid;
  logic [4:0]  wr0_addr, wr1_addr, rd_a1, rd_a2;
  logic [31:0] wr0_data, wr1_data;
  logic        wr0_ready, wr1_ready, rd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rd1, rsp_rd2;
  logic        rf_we;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_wd, rf_rd1, rf_rd2;

  // Register file the DUT drives: combinational reads, clocked write.
  logic [31:0] rf_mem [32];
  logic        rf_clear;
  assign rf_rd1 = rf_mem[rf_a1];
  assign rf_rd2 = rf_mem[rf_a2];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_we) begin
      rf_mem[rf_a1] <= rf_wd;
    end
  end

  always #5 clk = ~clk;

  rf_access_sequencer #(.N(32), .MAX_WR_STREAK(MAX)) dut (
    .clk(clk), .reset(reset),
    .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
    .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
    .rd_valid(rd_valid), .rd_a1(rd_a1), .rd_a2(rd_a2), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2),
    .rf_we(rf_we), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_wd(rf_wd),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: 0 idle, 1 wr0, 2 wr1, 3 read.
  int          m_rr, m_streak;
  logic [31:0] m_mem [32];
  logic        m_rsp_valid;
  logic [31:0] m_rsp1, m_rsp2;
  logic        obs_we;
  logic [4:0]  obs_a1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_streak = 0; m_rsp_valid = 1'b0; m_rsp1 = '0; m_rsp2 = '0;
  endtask

  function automatic int exp_grant();
    if (rd_valid && m_streak >= MAX) return 3;
    if (wr0_valid && wr1_valid) return (m_rr == 0) ? 1 : 2;
    if (wr0_valid) return 1;
    if (wr1_valid) return 2;
    if (rd_valid) return 3;
    return 0;
  endfunction

  // One clock cycle: inputs were applied after the falling edge. Compare all
  // outputs, advance the model, then return at the next falling edge.
  task automatic cycle(input string tag, output int og);
    int g;
    logic [4:0]  ea1;
    logic [31:0] ewd;
    #1;
    g   = exp_grant();
    ea1 = (g == 1) ? wr0_addr : (g == 2) ? wr1_addr : rd_a1;
    ewd = (g == 1) ? wr0_data : (g == 2) ? wr1_data : 32'h0;
    og  = wr0_ready ? 1 : wr1_ready ? 2 : rd_ready ? 3 : 0;
    obs_we = rf_we;
    obs_a1 = rf_a1;
    check({tag, ".onehot"}, 32'($countones({wr0_ready, wr1_ready, rd_ready}) <= 1), 32'd1);
    check({tag, ".grant"}, 32'(og), 32'(g));
    check({tag, ".rf_we"}, 32'(rf_we), 32'(g == 1 || g == 2));
    check({tag, ".rf_a1"}, 32'(rf_a1), 32'(ea1));
    check({tag, ".rf_a2"}, 32'(rf_a2), 32'(rd_a2));
    check({tag, ".rf_wd"}, rf_wd, ewd);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_rsp_valid));
    check({tag, ".rsp_rd1"}, rsp_rd1, m_rsp1);
    check({tag, ".rsp_rd2"}, rsp_rd2, m_rsp2);
    m_rsp_valid = (g == 3);
    if (g == 3) begin
      m_rsp1 = m_mem[rd_a1];
      m_rsp2 = m_mem[rd_a2];
    end
    if (g == 1) m_mem[wr0_addr] = wr0_data;
    if (g == 2) m_mem[wr1_addr] = wr1_data;
    if (g == 1 || g == 2) m_rr = (g == 1) ? 1 : 0;
    if ((g == 1 || g == 2) && rd_valid) m_streak = (m_streak < MAX) ? m_streak + 1 : MAX;
    else m_streak = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Requesters hold while waiting; otherwise present a fresh random request.
  task automatic drive_random(input int p, input int og);
    if (!(wr0_valid && og != 1)) begin
      wr0_valid = (int'($urandom_range(0, 99)) < p);
      wr0_addr  = 5'($urandom);
      wr0_data  = $urandom;
    end
    if (!(wr1_valid && og != 2)) begin
      wr1_valid = (int'($urandom_range(0, 99)) < p);
      wr1_addr  = 5'($urandom);
      wr1_data  = $urandom;
    end
    if (!(rd_valid && og != 3)) begin
      rd_valid = (int'($urandom_range(0, 99)) < p);
      rd_a1    = 5'($urandom);
      rd_a2    = 5'($urandom);
    end
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    check({tag, ".wr0_ready"}, 32'(wr0_ready), 32'd0);
    check({tag, ".wr1_ready"}, 32'(wr1_ready), 32'd0);
    check({tag, ".rd_ready"}, 32'(rd_ready), 32'd0);
    check({tag, ".rf_we"}, 32'(rf_we), 32'd0);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".rsp_rd1"}, rsp_rd1, 32'd0);
    check({tag, ".rsp_rd2"}, rsp_rd2, 32'd0);
  endtask

  task automatic idle_inputs();
    wr0_valid = 1'b0; wr1_valid = 1'b0; rd_valid = 1'b0;
  endtask

  initial begin
    int og, prev;
    reset = 1'b1; rf_clear = 1'b1;
    idle_inputs();
    wr0_addr = 5'd1; wr1_addr = 5'd2; rd_a1 = 5'd1; rd_a2 = 5'd2;
    wr0_data = 32'h11111111; wr1_data = 32'h22222222;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rf_clear = 1'b0;

    // Reset with every requester asserting.
    wr0_valid = 1'b1; wr1_valid = 1'b1; rd_valid = 1'b1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;
    cycle("rst_release", og);
    check("rst_first_wr0", 32'(og), 32'd1);
    for (int i = 0; i < 10 && (wr0_valid || wr1_valid || rd_valid); i++) begin
      drive_random(0, og);
      if (wr0_valid || wr1_valid || rd_valid) cycle("drain", og);
    end
    idle_inputs();

    // Single write then read of the same register.
    wr0_valid = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    cycle("wr_single", og);
    wr0_valid = 1'b0; rd_valid = 1'b1; rd_a1 = 5'd5; rd_a2 = 5'd0;
    cycle("rd_single", og);
    check("rd_single_gnt", 32'(og), 32'd3);
    rd_valid = 1'b0;
    check("rd_single_valid", 32'(rsp_valid), 32'd1);
    check("rd_single_rd1", rsp_rd1, 32'hDEADBEEF);
    check("rd_single_rd2", rsp_rd2, 32'h0);
    cycle("rd_after", og);

    // Two writers tied, no reader: grants must alternate.
    wr0_valid = 1'b1; wr0_addr = 5'd10; wr1_valid = 1'b1; wr1_addr = 5'd11;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wr0_data = $urandom; wr1_data = $urandom;
      cycle("rr", og);
      check("rr_is_write", 32'(og == 1 || og == 2), 32'd1);
      if (i > 0) check("rr_alternates", 32'(og != prev), 32'd1);
      prev = og;
    end

    // Both writers plus a reader: W W W R repeating.
    rd_valid = 1'b1; rd_a1 = 5'd10; rd_a2 = 5'd11;
    for (int i = 0; i < 12; i++) begin
      cycle("starve", og);
      check("starve_pattern", 32'(og == 3), 32'((i % 4) == 3));
    end
    idle_inputs();
    cycle("idle", og);

    // Shared A1: write to r7 first, then read address 3.
    wr1_valid = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h12345678;
    rd_valid = 1'b1; rd_a1 = 5'd3; rd_a2 = 5'd7;
    cycle("shared1", og);
    check("shared1_we", 32'(obs_we), 32'd1);
    check("shared1_a1", 32'(obs_a1), 32'd7);
    wr1_valid = 1'b0;
    cycle("shared2", og);
    check("shared2_we", 32'(obs_we), 32'd0);
    check("shared2_a1", 32'(obs_a1), 32'd3);
    check("shared2_gnt", 32'(og), 32'd3);
    rd_valid = 1'b0;

    // Reset while a read response is in flight.
    check("midrst_pre", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    model_reset();
    check_reset_state("midrst");
    @(negedge clk);
    reset = 1'b0;
    cycle("midrst_after", og);
    wr0_valid = 1'b1; wr0_addr = 5'd20; wr0_data = 32'hA5A5A5A5;
    wr1_valid = 1'b1; wr1_addr = 5'd21; wr1_data = 32'h5A5A5A5A;
    cycle("midrst_tie", og);
    check("midrst_tie_wr0", 32'(og), 32'd1);
    wr0_valid = 1'b0;
    cycle("midrst_wr1", og);
    wr1_valid = 1'b0;

    // Randomized traffic at several load levels.
    og = 0;
    for (int p = 30; p <= 90; p += 30) begin
      for (int i = 0; i < 200; i++) begin
        drive_random(p, og);
        cycle("rand", og);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
